// File: rtl/onedcfnn_regs_pkg.sv
// Shared word map, CTRL/status bit positions and response codes for the
// OneDCFNN AXI4-Lite register file.
package onedcfnn_regs_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned NUM_CFG = 4;

  typedef logic [2:0] word_idx_t;

  localparam word_idx_t REG_CFG0    = 3'd0;
  localparam word_idx_t REG_CFG1    = 3'd1;
  localparam word_idx_t REG_CFG2    = 3'd2;
  localparam word_idx_t REG_CFG3    = 3'd3;
  localparam word_idx_t REG_CTRL    = 3'd4;
  localparam word_idx_t REG_RESULT  = 3'd5;
  localparam word_idx_t REG_VERSION = 3'd6;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;

  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_DONE_BIT = 1;
  localparam int unsigned STAT_ERR_BIT  = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic [DATA_W-1:0] apply_wstrb(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/onedcfnn_axil_wr_ctrl.sv
// AXI4-Lite write-side handshake: independent AW/W capture, single commit
// strobe and B response hold.
module onedcfnn_axil_wr_ctrl
  import onedcfnn_regs_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic              commit_o,
  output word_idx_t         idx_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o
);

  logic              aw_held_q, aw_held_d;
  word_idx_t         idx_q, idx_d;
  logic              w_held_q, w_held_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic              aw_hs, w_hs, commit;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^awaddr_i[1:0];

  assign awready_o = !aw_held_q && !bvalid_q;
  assign wready_o  = !w_held_q && !bvalid_q;
  assign bvalid_o  = bvalid_q;

  assign aw_hs = awvalid_i && awready_o;
  assign w_hs  = wvalid_i && wready_o;

  // A handshake landing this cycle counts as held, so the commit can be
  // combinational on the same edge the last half arrives.
  assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign commit_o = commit;
  assign idx_o    = aw_held_q ? idx_q   : awaddr_i[4:2];
  assign wdata_o  = w_held_q  ? wdata_q : wdata_i;
  assign wstrb_o  = w_held_q  ? wstrb_q : wstrb_i;

  always_comb begin
    aw_held_d = aw_held_q;
    idx_d     = idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      idx_d     = awaddr_i[4:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else if (bready_i) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held_q <= 1'b0;
      idx_q     <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      idx_q     <= idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
    end
  end

endmodule

// File: rtl/onedcfnn_axil_regs.sv
// AXI4-Lite register file for the OneDCFNN core: four config words,
// start/clear control, done/error status, captured result and version.
module onedcfnn_axil_regs
  import onedcfnn_regs_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] VERSION_ID         = 32'h0001_0000
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] cfg_words,
  output logic                            core_start,
  input  logic                            core_busy,
  input  logic                            core_done,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   core_result
);

  logic              wr_commit;
  word_idx_t         wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;

  logic [DATA_W-1:0] cfg_q [NUM_CFG];
  logic [DATA_W-1:0] cfg_d [NUM_CFG];
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              ctrl_wr, start_req, clear_req;
  logic              ar_hs;
  word_idx_t         ar_idx;
  logic [DATA_W-1:0] status, rd_mux;
  logic              unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

  onedcfnn_axil_wr_ctrl #(
    .ADDR_W (C_S_AXI_ADDR_WIDTH)
  ) u_wr_ctrl (
    .clk_i     (S_AXI_ACLK),
    .rst_ni    (S_AXI_ARESETN),
    .awaddr_i  (S_AXI_AWADDR),
    .awvalid_i (S_AXI_AWVALID),
    .awready_o (S_AXI_AWREADY),
    .wdata_i   (S_AXI_WDATA),
    .wstrb_i   (S_AXI_WSTRB),
    .wvalid_i  (S_AXI_WVALID),
    .wready_o  (S_AXI_WREADY),
    .bvalid_o  (S_AXI_BVALID),
    .bready_i  (S_AXI_BREADY),
    .commit_o  (wr_commit),
    .idx_o     (wr_idx),
    .wdata_o   (wr_data),
    .wstrb_o   (wr_strb)
  );

  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign core_start    = start_q;
  assign cfg_words     = {cfg_q[3], cfg_q[2], cfg_q[1], cfg_q[0]};

  assign ctrl_wr   = wr_commit && (wr_idx == REG_CTRL) && wr_strb[0];
  assign start_req = ctrl_wr && wr_data[CTRL_START_BIT];
  assign clear_req = ctrl_wr && wr_data[CTRL_CLEAR_BIT];

  always_comb begin
    for (int unsigned i = 0; i < NUM_CFG; i++) cfg_d[i] = cfg_q[i];
    if (wr_commit && !wr_idx[2]) begin
      cfg_d[wr_idx[1:0]] = apply_wstrb(cfg_q[wr_idx[1:0]], wr_data, wr_strb);
    end
  end

  // Clear is applied first so that a coincident done pulse or a refused
  // start still leaves its sticky bit set.
  always_comb begin
    start_d  = start_req && !core_busy;
    err_d    = err_q;
    done_d   = done_q;
    result_d = result_q;
    if (clear_req) begin
      err_d  = 1'b0;
      done_d = 1'b0;
    end
    if (start_req && core_busy) err_d = 1'b1;
    if (core_done) begin
      done_d   = 1'b1;
      result_d = core_result;
    end
  end

  assign ar_hs  = S_AXI_ARVALID && !rvalid_q;
  assign ar_idx = S_AXI_ARADDR[4:2];

  always_comb begin
    status                = '0;
    status[STAT_BUSY_BIT] = core_busy;
    status[STAT_DONE_BIT] = done_q;
    status[STAT_ERR_BIT]  = err_q;
  end

  // Read mux samples the current register state, so a same-cycle write to
  // the same word is not visible in this read.
  always_comb begin
    case (ar_idx)
      REG_CFG0, REG_CFG1,
      REG_CFG2, REG_CFG3: rd_mux = cfg_q[ar_idx[1:0]];
      REG_CTRL:           rd_mux = status;
      REG_RESULT:         rd_mux = result_q;
      REG_VERSION:        rd_mux = VERSION_ID;
      default:            rd_mux = '0;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      result_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CFG; i++) cfg_q[i] <= cfg_d[i];
      done_q   <= done_d;
      err_q    <= err_d;
      start_q  <= start_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
